// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - multiplexed 7-segment scanner with dead time and frame-aligned updates
// Optional SEVEN_SEG_LEADING_ZERO_BLANK_EN adds the zeroSuppress input for leading-zero blanking.
module seven_seg_scanner #(
  parameter int NUM_DIGITS  = 4,
  parameter int SLOT_CYCLES = 100000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digitValues,
  input  logic [NUM_DIGITS-1:0]   dpMask,
  input  logic [NUM_DIGITS-1:0]   blankMask,
  input  logic                    loadStrobe,
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
  input  logic                    zeroSuppress,
`endif
  output logic [7:0]              segments,
  output logic [NUM_DIGITS-1:0]   digitEnable,
  output logic                    frameStart
);

  localparam int CNT_W  = $clog2(SLOT_CYCLES + 1);
  localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0]  DEAD_END  = CNT_W'(DEAD_CYCLES);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(NUM_DIGITS - 1);

  typedef enum logic {ST_DEAD, ST_DRIVE} state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SLOT_W-1:0]       slot_q, slot_d;
  logic                    first_q, first_d;
  logic [4*NUM_DIGITS-1:0] shadow_val_q, shadow_val_d, pend_val_q, pend_val_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d, pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   shadow_blank_q, shadow_blank_d, pend_blank_q, pend_blank_d;
  logic                    pend_flag_q, pend_flag_d;
  logic [7:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   en_q, en_d;
  logic                    frame_q, frame_d;

  logic                    slot_wrap, boundary, keep, blank;
  logic [3:0]              nib;
  logic [NUM_DIGITS-1:0]   suppress;

  // Lit pattern in gfedcba order, i.e. bit 0 is segment a.
  function automatic logic [6:0] decode(input logic [3:0] n);
    case (n)
      4'h0:    decode = 7'b0111111;
      4'h1:    decode = 7'b0000110;
      4'h2:    decode = 7'b1011011;
      4'h3:    decode = 7'b1001111;
      4'h4:    decode = 7'b1100110;
      4'h5:    decode = 7'b1101101;
      4'h6:    decode = 7'b1111101;
      4'h7:    decode = 7'b0000111;
      4'h8:    decode = 7'b1111111;
      4'h9:    decode = 7'b1101111;
      4'hA:    decode = 7'b1110111;
      4'hB:    decode = 7'b1111100;
      4'hC:    decode = 7'b0111001;
      4'hD:    decode = 7'b1011110;
      4'hE:    decode = 7'b1111001;
      default: decode = 7'b1110001;
    endcase
  endfunction

  always_comb begin
    slot_wrap = (cnt_q == CNT_LAST);
    boundary  = first_q || (slot_wrap && (slot_q == SLOT_LAST));

    cnt_d  = slot_wrap ? '0 : cnt_q + CNT_W'(1);
    slot_d = slot_q;
    if (slot_wrap) slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + SLOT_W'(1);
    state_d = (cnt_d < DEAD_END) ? ST_DEAD : ST_DRIVE;
    first_d = 1'b0;

    shadow_val_d   = shadow_val_q;
    shadow_dp_d    = shadow_dp_q;
    shadow_blank_d = shadow_blank_q;
    pend_val_d     = pend_val_q;
    pend_dp_d      = pend_dp_q;
    pend_blank_d   = pend_blank_q;
    pend_flag_d    = pend_flag_q;

    // A strobe on the boundary itself bypasses pending so it is not a frame late.
    if (boundary) begin
      if (loadStrobe) begin
        shadow_val_d   = digitValues;
        shadow_dp_d    = dpMask;
        shadow_blank_d = blankMask;
      end else if (pend_flag_q) begin
        shadow_val_d   = pend_val_q;
        shadow_dp_d    = pend_dp_q;
        shadow_blank_d = pend_blank_q;
      end
      pend_flag_d = 1'b0;
    end else if (loadStrobe) begin
      pend_val_d   = digitValues;
      pend_dp_d    = dpMask;
      pend_blank_d = blankMask;
      pend_flag_d  = 1'b1;
    end

    keep     = 1'b0;
    suppress = '0;
`ifdef SEVEN_SEG_LEADING_ZERO_BLANK_EN
    // Scan from the top digit; the first non-zero or dp-lit digit stops suppression below it.
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      if ((shadow_val_q[4*i +: 4] != 4'h0) || shadow_dp_q[i]) keep = 1'b1;
      suppress[i] = zeroSuppress & ~keep;
    end
`endif

    nib   = shadow_val_q[4*int'(slot_q) +: 4];
    blank = shadow_blank_q[slot_q] | suppress[slot_q];
    seg_d = 8'hFF;
    en_d  = '1;
    if (state_q == ST_DRIVE) begin
      en_d[slot_q] = 1'b0;
      if (!blank) seg_d = {~shadow_dp_q[slot_q], ~decode(nib)};
    end
    frame_d = (slot_q == '0) && (cnt_q == '0);
  end

  always_ff @(negedge clk) begin
    if (reset) begin
      state_q        <= ST_DEAD;
      cnt_q          <= '0;
      slot_q         <= '0;
      first_q        <= 1'b1;
      shadow_val_q   <= '0;
      shadow_dp_q    <= '0;
      shadow_blank_q <= '0;
      pend_val_q     <= '0;
      pend_dp_q      <= '0;
      pend_blank_q   <= '0;
      pend_flag_q    <= 1'b0;
      seg_q          <= 8'hFF;
      en_q           <= '1;
      frame_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      slot_q         <= slot_d;
      first_q        <= first_d;
      shadow_val_q   <= shadow_val_d;
      shadow_dp_q    <= shadow_dp_d;
      shadow_blank_q <= shadow_blank_d;
      pend_val_q     <= pend_val_d;
      pend_dp_q      <= pend_dp_d;
      pend_blank_q   <= pend_blank_d;
      pend_flag_q    <= pend_flag_d;
      seg_q          <= seg_d;
      en_q           <= en_d;
      frame_q        <= frame_d;
    end
  end

  assign segments    = seg_q;
  assign digitEnable = en_q;
  assign frameStart  = frame_q;

endmodule
